// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : Instruction phase generator for the instruction controller.
//                Steps a 3-bit phase 0..7 once per cycle while running, with
//                start/resume, single-step pause, memory wait-state stalls,
//                a halt sampled in one phase and a retired-instruction count.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
  parameter int         ICNT_W     = 16,
  parameter logic [2:0] HALT_PHASE = 3'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic              step_en,
  input  logic              mem_wait,
  input  logic              halt,
  output logic [2:0]        phase,
  output logic              running,
  output logic              halted,
  output logic              paused,
  output logic              fetch_start,
  output logic              instr_done,
  output logic [ICNT_W-1:0] instr_count
);

  // Last phase of an instruction; leaving it retires the instruction.
  localparam logic [2:0]        c_LAST_PHASE = 3'd7;
  localparam logic [2:0]        c_PHASE_ONE  = 3'd1;
  localparam logic [ICNT_W-1:0] c_CNT_ONE    = ICNT_W'(1);

  // All four 2-bit codes are assigned; the default arm still returns to IDLE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_PAUSE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [2:0]        r_phase;
  logic              r_fetch_start;
  logic              r_instr_done;
  logic [ICNT_W-1:0] r_instr_count;

  state_t            w_state_nxt;
  logic [2:0]        w_phase_nxt;
  logic              w_fetch_start_nxt;
  logic              w_instr_done_nxt;
  logic [ICNT_W-1:0] w_instr_count_nxt;

  // State, phase, pulse and counter registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_phase       <= 3'd0;
      r_fetch_start <= 1'b0;
      r_instr_done  <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_fetch_start <= w_fetch_start_nxt;
      r_instr_done  <= w_instr_done_nxt;
      r_instr_count <= w_instr_count_nxt;
    end
  end

  // Next state and next registered outputs; priority clear > stall > halt > start/step.
  always_comb begin
    w_state_nxt       = r_state;
    w_phase_nxt       = r_phase;
    w_fetch_start_nxt = 1'b0;
    w_instr_done_nxt  = 1'b0;
    w_instr_count_nxt = r_instr_count;

    if (clear) begin
      w_state_nxt       = S_IDLE;
      w_phase_nxt       = 3'd0;
      w_instr_count_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_phase_nxt = 3'd0;
          // A stall outranks start, so start is only taken with mem_wait low.
          if (!mem_wait && start) begin
            w_state_nxt       = S_RUN;
            w_fetch_start_nxt = 1'b1;
          end
        end

        S_RUN: begin
          if (mem_wait) begin
            // Full hold: phase, state and count frozen, pulses dropped.
            w_phase_nxt = r_phase;
          end else if ((r_phase == HALT_PHASE) && halt) begin
            w_state_nxt = S_HALTED;
          end else begin
            w_phase_nxt = r_phase + c_PHASE_ONE;
            if (r_phase == c_LAST_PHASE) begin
              // Retiring an instruction: count and done pulse land together.
              w_instr_count_nxt = r_instr_count + c_CNT_ONE;
              w_instr_done_nxt  = 1'b1;
              if (step_en) begin
                w_state_nxt = S_PAUSE;
              end else begin
                w_fetch_start_nxt = 1'b1;
              end
            end
          end
        end

        S_HALTED: begin
          // Halt and stall are both ignored here; only start resumes.
          w_phase_nxt = HALT_PHASE;
          if (start) begin
            w_state_nxt = S_RUN;
            w_phase_nxt = HALT_PHASE + c_PHASE_ONE;
          end
        end

        S_PAUSE: begin
          w_phase_nxt = 3'd0;
          if (!mem_wait && start) begin
            w_state_nxt       = S_RUN;
            w_fetch_start_nxt = 1'b1;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = 3'd0;
        end
      endcase
    end
  end

  // Status flags are plain decodes of the state register.
  assign running     = (r_state == S_RUN);
  assign halted      = (r_state == S_HALTED);
  assign paused      = (r_state == S_PAUSE);

  assign phase       = r_phase;
  assign fetch_start = r_fetch_start;
  assign instr_done  = r_instr_done;
  assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_sequencer
//  Description : Self-checking bench for phase_sequencer. A reference model
//                predicts every cycle's outputs into a queue; a monitor pops
//                and compares one entry after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

  localparam int ICNT_W = 4;
  localparam int CMOD   = 1 << ICNT_W;
  localparam int HP     = 4;

  // Model modes
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_HALTED = 2;
  localparam int M_PAUSE  = 3;

  typedef struct packed {
    logic [2:0]        ph;
    logic              run;
    logic              hlt;
    logic              pau;
    logic              fs;
    logic              id;
    logic [ICNT_W-1:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic step_en = 1'b0;
  logic mem_wait = 1'b0;
  logic halt = 1'b0;

  logic [2:0]        phase;
  logic              running;
  logic              halted;
  logic              paused;
  logic              fetch_start;
  logic              instr_done;
  logic [ICNT_W-1:0] instr_count;

  phase_sequencer #(
    .ICNT_W    (ICNT_W),
    .HALT_PHASE(3'(HP))
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .start      (start),
    .step_en    (step_en),
    .mem_wait   (mem_wait),
    .halt       (halt),
    .phase      (phase),
    .running    (running),
    .halted     (halted),
    .paused     (paused),
    .fetch_start(fetch_start),
    .instr_done (instr_done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  obs_t exp_q[$];

  // Reference model: operating mode, position within the instruction,
  // total instructions retired (unbounded), and this cycle's pulses.
  int m_mode    = M_IDLE;
  int m_ph      = 0;
  int m_retired = 0;
  bit m_fs      = 0;
  bit m_id      = 0;
  bit stepv     = 0;

  function automatic obs_t sample_dut();
    obs_t o;
    o = {phase, running, halted, paused, fetch_start, instr_done, instr_count};
    return o;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.ph  = 3'(m_ph);
    o.run = (m_mode == M_RUN);
    o.hlt = (m_mode == M_HALTED);
    o.pau = (m_mode == M_PAUSE);
    o.fs  = m_fs;
    o.id  = m_id;
    o.cnt = ICNT_W'(m_retired % CMOD);
    return o;
  endfunction

  function automatic void model_reset();
    m_mode    = M_IDLE;
    m_ph      = 0;
    m_retired = 0;
    m_fs      = 0;
    m_id      = 0;
  endfunction

  // One clock edge of the behaviour, straight from the rules.
  function automatic void model_step(bit c, bit s, bit st, bit mw, bit h);
    m_fs = 0;
    m_id = 0;
    if (c) begin
      m_mode    = M_IDLE;
      m_ph      = 0;
      m_retired = 0;
    end else if (m_mode == M_RUN) begin
      if (mw) begin
        // stalled: nothing moves
      end else if (m_ph == HP && h) begin
        m_mode = M_HALTED;
      end else begin
        m_ph = (m_ph + 1) % 8;
        if (m_ph == 0) begin
          m_retired++;
          m_id = 1;
          if (st) m_mode = M_PAUSE;
          else    m_fs   = 1;
        end
      end
    end else if (m_mode == M_HALTED) begin
      if (s) begin
        m_mode = M_RUN;
        m_ph   = (HP + 1) % 8;
      end
    end else begin
      if (!mw && s) begin
        m_mode = M_RUN;
        m_ph   = 0;
        m_fs   = 1;
      end
    end
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the result, let the edge happen.
  task automatic cyc(input bit c, input bit s, input bit st, input bit mw, input bit h);
    clear    = c;
    start    = s;
    step_en  = st;
    mem_wait = mw;
    halt     = h;
    model_step(c, s, st, mw, h);
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, stepv, 0, 0);
  endtask

  task automatic run_to_phase(input int p);
    int guard;
    guard = 0;
    while (!(m_mode == M_RUN && m_ph == p) && guard < 40) begin
      idle_cyc();
      guard++;
    end
    check("run_to_phase_bound", int'(guard < 40), 1);
  endtask

  // Monitor: one prediction per edge, compared just after the edge.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample_dut();
        check("cycle_outputs{ph,run,hlt,pau,fs,id,cnt}", int'(a), int'(e));
      end
    end
  end

  initial begin
    // Reset held across a few edges, released between edges.
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", int'(sample_dut()), 0);
    rst_n = 1'b1;
    model_reset();

    // Basic instruction: fetch pulse, 1..7, wrap with done/fetch/count=1.
    cyc(0, 1, 0, 0, 0);
    repeat (8) idle_cyc();
    check("first_instr_count", int'(instr_count), 1);

    // Stall at phase 2 for three cycles.
    run_to_phase(2);
    repeat (3) cyc(0, 0, 0, 1, 0);
    idle_cyc();
    check("after_stall_phase", int'(phase), 3);

    // Halt at phase 4, hold with inputs toggling, then resume at 5.
    run_to_phase(4);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, i[0], (i % 3) == 0);
    check("halted_phase", int'(phase), HP);
    cyc(0, 1, 0, 0, 0);
    check("resume_phase", int'(phase), HP + 1);
    idle_cyc();

    // Stall outranks halt at phase 4.
    run_to_phase(4);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    check("stall_beats_halt", int'(halted), 0);
    cyc(0, 0, 0, 0, 1);
    check("halt_after_stall", int'(halted), 1);
    cyc(0, 1, 0, 0, 0);

    // Single-step: three starts give exactly three instructions.
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 0);
      repeat (8) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      check("step_paused", int'(paused), 1);
    end
    check("step_count", int'(instr_count), 3);

    // Counter wrap: 17 instructions modulo 16.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (17 * 8) idle_cyc();
    check("wrap_count", int'(instr_count), 1);

    // Asynchronous reset at phase 5, observed with no clock edge.
    run_to_phase(5);
    #1 rst_n = 1'b0;
    #1 check("async_reset", int'(sample_dut()), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();

    // Clear while halted.
    cyc(0, 1, 0, 0, 0);
    run_to_phase(4);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    check("clear_halted", int'(halted), 0);

    // Random traffic.
    stepv = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39) == 0) stepv = ~stepv;
      cyc($urandom_range(63) == 0, $urandom_range(3) == 0, stepv,
          $urandom_range(3) == 0, $urandom_range(2) == 0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
